// File: rtl/baverage_change.sv
// Change dispenser for the beverage vending path: checks whether a change amount
// can be paid from the coin stock, then hands out 1-Euro/50c coins over valid/ack.
module baverage_change #(
    parameter int AMT_W = 4,
    parameter int INV_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             refill,
    input  logic [INV_W-1:0] refill_50,
    input  logic [INV_W-1:0] refill_100,
    output logic [1:0]       coin,
    output logic             coin_valid,
    input  logic             coin_ack,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [INV_W-1:0] inv_50,
    output logic [INV_W-1:0] inv_100
);

    localparam int EXT_W = ((AMT_W > INV_W) ? AMT_W : INV_W) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_50   = 2'b01;
    localparam logic [1:0] COIN_100  = 2'b10;

    logic [1:0]       state;
    logic [AMT_W-1:0] rem;

    logic [EXT_W-1:0] amtExt;
    logic [EXT_W-1:0] halfAmt;
    logic [EXT_W-1:0] inv100Ext;
    logic [EXT_W-1:0] ones;
    logic [EXT_W-1:0] halves;
    logic             infeasible;
    logic [1:0]       firstCoin;

    logic             isEuro;
    logic [AMT_W-1:0] remNext;
    logic [INV_W-1:0] inv100Next;
    logic [1:0]       nextCoin;

    // Feasibility: greedy use of 1-Euro coins, the rest must fit in the 50c stock.
    always_comb begin
        amtExt     = EXT_W'(amount);
        halfAmt    = amtExt >> 1;
        inv100Ext  = EXT_W'(inv_100);
        ones       = (halfAmt < inv100Ext) ? halfAmt : inv100Ext;
        halves     = amtExt - (ones << 1);
        infeasible = halves > EXT_W'(inv_50);
        firstCoin  = (amount >= AMT_W'(2) && inv_100 != '0) ? COIN_100 : COIN_50;
    end

    // Post-acceptance view, used to present the next coin without a bubble.
    always_comb begin
        isEuro     = (coin == COIN_100);
        remNext    = rem - (isEuro ? AMT_W'(2) : AMT_W'(1));
        inv100Next = inv_100 - INV_W'(isEuro);
        nextCoin   = (remNext >= AMT_W'(2) && inv100Next != '0) ? COIN_100 : COIN_50;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rem        <= '0;
            coin       <= COIN_NONE;
            coin_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            inv_50     <= '0;
            inv_100    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (refill) begin
                        inv_50  <= refill_50;
                        inv_100 <= refill_100;
                    end else if (req) begin
                        rem  <= amount;
                        busy <= 1'b1;
                        if (amount == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (infeasible) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            coin       <= firstCoin;
                            coin_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (coin_valid && coin_ack) begin
                        rem <= remNext;
                        if (isEuro) begin
                            inv_100 <= inv100Next;
                        end else begin
                            inv_50 <= inv_50 - INV_W'(1);
                        end
                        if (remNext != '0) begin
                            coin <= nextCoin;
                        end else begin
                            coin       <= COIN_NONE;
                            coin_valid <= 1'b0;
                            state      <= DONE;
                            done       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    coin       <= COIN_NONE;
                    coin_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
